mmio_timer_pwm: RTL and testbench

Parametrised memory-mapped peripheral block for the single-cycle RISC-V core, decoded in the 0xFFFFFF00–0xFFFFFFFF page beside data memory. It provides NUM_PWM PWM channels with PWM_BITS resolution and a programmable prescaler, plus free-running `millis`/`micros` counters. It also has a compare timer that raises a level interrupt in one-shot or periodic mode. Loads and stores use RISC-V funct3 semantics with one-cycle registered read data, the same as data memory, so the core mux can treat both alike.

---
 rtl/periph_pkg.sv | 37 +++
 rtl/pwm_bank.sv | 40 ++++
 rtl/mmio_timer_pwm.sv | 191 +++++++++++++++++++
 tb/tb_mmio_timer_pwm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Shared constants and types for the MMIO timer/PWM peripheral page.
package periph_pkg;

   localparam logic [23:0] PAGE_BASE  = 24'hFFFFFF;

   localparam logic [7:0]  OFF_PRESC  = 8'h80;
   localparam logic [7:0]  OFF_TCOUNT = 8'hE8;
   localparam logic [7:0]  OFF_TCTRL  = 8'hEC;
   localparam logic [7:0]  OFF_TCMP   = 8'hF0;
   localparam logic [7:0]  OFF_MICROS = 8'hF4;
   localparam logic [7:0]  OFF_MILLIS = 8'hF8;

   // funct3 bit meanings for loads and stores
   localparam int unsigned F3_HALF_BIT = 0;
   localparam int unsigned F3_WORD_BIT = 1;
   localparam int unsigned F3_UNS_BIT  = 2;

   typedef struct packed {
      logic irq_pending;
      logic irq_en;
      logic periodic;
      logic en;
   } tctrl_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_RUN,
      T_FIRED
   } tstate_e;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [31:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

endpackage

// File: rtl/pwm_bank.sv
// Prescaled free-running PWM counter shared by NUM_PWM duty comparators.
module pwm_bank #(
   parameter int unsigned NUM_PWM  = 4,
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NUM_PWM-1:0][PWM_BITS-1:0]   duty_i,
   input  logic [15:0]                        presc_i,
   input  logic                               presc_wr_i,
   output logic [NUM_PWM-1:0]                 pwm_o
);

   logic [15:0]         presc_cnt_q, presc_cnt_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                tick;

   always_comb begin
      tick        = (presc_cnt_q == presc_i);
      presc_cnt_d = tick ? '0 : presc_cnt_q + 16'd1;
      if (presc_wr_i) presc_cnt_d = '0;
      pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         presc_cnt_q <= '0;
         pwm_cnt_q   <= '0;
      end else begin
         presc_cnt_q <= presc_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
      end
   end

   always_comb begin
      pwm_o = '0;
      for (int unsigned i = 0; i < NUM_PWM; i++) pwm_o[i] = (pwm_cnt_q < duty_i[i]);
   end

endmodule

// File: rtl/mmio_timer_pwm.sv
// Memory-mapped PWM bank, micros/millis counters and compare timer with
// registered, funct3-extracted read data matching the data-memory timing.
module mmio_timer_pwm #(
   parameter int unsigned CLK_FREQ = 12000000,
   parameter int unsigned NUM_PWM  = 4,
   parameter int unsigned PWM_BITS = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         funct3,
   input  logic               periph_wren,
   input  logic [31:0]        periph_address,
   input  logic [31:0]        periph_data_in,
   output logic [31:0]        periph_data_out,
   output logic [NUM_PWM-1:0] pwm_out,
   output logic               irq
);
   import periph_pkg::*;

   localparam int unsigned US_DIV = CLK_FREQ / 1000000;
   localparam int unsigned MS_DIV = CLK_FREQ / 1000;

   logic [NUM_PWM-1:0][PWM_BITS-1:0] duty_q, duty_d;
   logic [15:0]  presc_q, presc_d;
   logic [31:0]  tcount_q, tcount_d, tcmp_q, tcmp_d;
   logic         per_q, per_d, irqen_q, irqen_d, pend_q, pend_d;
   tstate_e      state_q, state_d;
   logic [31:0]  us_div_q, ms_div_q, micros_q, millis_q;
   logic [31:0]  rdata_q;
   logic [2:0]   f3_q;
   logic [1:0]   addr_q;

   logic         sel, we, us_tick, ms_tick, hw_set, w1c;
   logic [7:0]   off;
   logic [4:0]   duty_idx;
   logic [3:0]   be;
   logic [31:0]  wdata, wmask, rd_word;
   tctrl_t       ctrl_rd, ctrl_wr;

   assign sel      = (periph_address[31:8] == PAGE_BASE);
   assign off      = {periph_address[7:2], 2'b00};
   assign duty_idx = periph_address[6:2];
   assign we       = periph_wren & sel;
   assign us_tick  = (us_div_q == US_DIV - 1);
   assign ms_tick  = (ms_div_q == MS_DIV - 1);
   assign ctrl_rd  = '{irq_pending: pend_q, irq_en: irqen_q, periodic: per_q,
                       en: (state_q == T_RUN)};

   always_comb begin
      if (funct3[F3_WORD_BIT]) begin
         be    = 4'b1111;
         wdata = periph_data_in;
      end else if (funct3[F3_HALF_BIT]) begin
         be    = periph_address[1] ? 4'b1100 : 4'b0011;
         wdata = {2{periph_data_in[15:0]}};
      end else begin
         be    = 4'b0001 << periph_address[1:0];
         wdata = {4{periph_data_in[7:0]}};
      end
      wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   end

   always_comb begin
      rd_word = '0;
      if (sel) begin
         if (!periph_address[7]) begin
            for (int unsigned i = 0; i < NUM_PWM; i++)
               if (duty_idx == 5'(i)) rd_word[PWM_BITS-1:0] = duty_q[i];
         end else begin
            case (off)
               OFF_PRESC:  rd_word[15:0] = presc_q;
               OFF_TCOUNT: rd_word       = tcount_q;
               OFF_TCTRL:  rd_word[3:0]  = ctrl_rd;
               OFF_TCMP:   rd_word       = tcmp_q;
               OFF_MICROS: rd_word       = micros_q;
               OFF_MILLIS: rd_word       = millis_q;
               default:    rd_word       = '0;
            endcase
         end
      end
   end

   always_comb begin
      duty_d  = duty_q;
      presc_d = presc_q;
      if (we && !periph_address[7]) begin
         for (int unsigned i = 0; i < NUM_PWM; i++)
            if (duty_idx == 5'(i))
               duty_d[i] = PWM_BITS'(merge_lanes(32'(duty_q[i]), wdata, wmask));
      end
      if (we && off == OFF_PRESC) presc_d = 16'(merge_lanes({16'b0, presc_q}, wdata, wmask));
   end

   // Hardware update first; software writes then override per field, except
   // that a match-cycle pending set survives a simultaneous W1C.
   always_comb begin
      state_d  = state_q;
      tcount_d = tcount_q;
      tcmp_d   = tcmp_q;
      per_d    = per_q;
      irqen_d  = irqen_q;
      hw_set   = 1'b0;
      w1c      = 1'b0;
      ctrl_wr  = '0;
      case (state_q)
         T_RUN: begin
            if (us_tick) begin
               if (tcount_q == tcmp_q) begin
                  hw_set = 1'b1;
                  if (per_q) tcount_d = '0;
                  else       state_d  = T_FIRED;
               end else begin
                  tcount_d = tcount_q + 32'd1;
               end
            end
         end
         default: ;
      endcase
      if (we && off == OFF_TCOUNT) tcount_d = merge_lanes(tcount_q, wdata, wmask);
      if (we && off == OFF_TCMP)   tcmp_d   = merge_lanes(tcmp_q, wdata, wmask);
      if (we && off == OFF_TCTRL && be[0]) begin
         ctrl_wr = tctrl_t'(wdata[3:0]);
         state_d = ctrl_wr.en ? T_RUN : T_IDLE;
         per_d   = ctrl_wr.periodic;
         irqen_d = ctrl_wr.irq_en;
         w1c     = ctrl_wr.irq_pending;
      end
      pend_d = hw_set | (pend_q & ~w1c);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         duty_q   <= '0;
         presc_q  <= '0;
         tcount_q <= '0;
         tcmp_q   <= '0;
         per_q    <= 1'b0;
         irqen_q  <= 1'b0;
         pend_q   <= 1'b0;
         state_q  <= T_IDLE;
         us_div_q <= '0;
         ms_div_q <= '0;
         micros_q <= '0;
         millis_q <= '0;
         rdata_q  <= '0;
         f3_q     <= '0;
         addr_q   <= '0;
      end else begin
         duty_q   <= duty_d;
         presc_q  <= presc_d;
         tcount_q <= tcount_d;
         tcmp_q   <= tcmp_d;
         per_q    <= per_d;
         irqen_q  <= irqen_d;
         pend_q   <= pend_d;
         state_q  <= state_d;
         us_div_q <= us_tick ? '0 : us_div_q + 32'd1;
         ms_div_q <= ms_tick ? '0 : ms_div_q + 32'd1;
         micros_q <= micros_q + {31'b0, us_tick};
         millis_q <= millis_q + {31'b0, ms_tick};
         rdata_q  <= rd_word;
         f3_q     <= funct3;
         addr_q   <= periph_address[1:0];
      end
   end

   always_comb begin
      logic [15:0] h;
      logic [7:0]  b;
      h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      b = rdata_q[{addr_q, 3'b000} +: 8];
      if (f3_q[F3_WORD_BIT])      periph_data_out = rdata_q;
      else if (f3_q[F3_HALF_BIT]) periph_data_out = f3_q[F3_UNS_BIT] ? {16'b0, h} : {{16{h[15]}}, h};
      else                        periph_data_out = f3_q[F3_UNS_BIT] ? {24'b0, b} : {{24{b[7]}}, b};
   end

   assign irq = pend_q & irqen_q;

   pwm_bank #(
      .NUM_PWM  (NUM_PWM),
      .PWM_BITS (PWM_BITS)
   ) u_pwm_bank (
      .clk_i      (clk),
      .rst_ni     (reset),
      .duty_i     (duty_q),
      .presc_i    (presc_q),
      .presc_wr_i (we && off == OFF_PRESC),
      .pwm_o      (pwm_out)
   );

endmodule

// File: tb/tb_mmio_timer_pwm.sv
// Directed self-checking bench for mmio_timer_pwm at 12 MHz, 4 x 8-bit PWM.
module tb_mmio_timer_pwm;

   localparam logic [31:0] A_DUTY0  = 32'hFFFF_FF00;
   localparam logic [31:0] A_DUTY2  = 32'hFFFF_FF08;
   localparam logic [31:0] A_DUTY5  = 32'hFFFF_FF14;
   localparam logic [31:0] A_PRESC  = 32'hFFFF_FF80;
   localparam logic [31:0] A_UNMAP  = 32'hFFFF_FF90;
   localparam logic [31:0] A_TCOUNT = 32'hFFFF_FFE8;
   localparam logic [31:0] A_TCTRL  = 32'hFFFF_FFEC;
   localparam logic [31:0] A_TCMP   = 32'hFFFF_FFF0;
   localparam logic [31:0] A_MICROS = 32'hFFFF_FFF4;
   localparam logic [31:0] A_MILLIS = 32'hFFFF_FFF8;
   localparam logic [2:0]  LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  funct3 = '0;
   logic        periph_wren = 1'b0;
   logic [31:0] periph_address = '0;
   logic [31:0] periph_data_in = '0;
   logic [31:0] periph_data_out;
   logic [3:0]  pwm_out;
   logic        irq;

   int tests = 0;
   int fails = 0;

   mmio_timer_pwm #(
      .CLK_FREQ (12000000),
      .NUM_PWM  (4),
      .PWM_BITS (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .funct3          (funct3),
      .periph_wren     (periph_wren),
      .periph_address  (periph_address),
      .periph_data_in  (periph_data_in),
      .periph_data_out (periph_data_out),
      .pwm_out         (pwm_out),
      .irq             (irq)
   );

   always #5 clk = ~clk;

   // All bus tasks are entered and left at a falling edge.
   task automatic bus_write(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
      periph_address = a; funct3 = f3; periph_data_in = d; periph_wren = 1'b1;
      @(negedge clk);
      periph_wren = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] d);
      periph_address = a; funct3 = f3; periph_wren = 1'b0;
      @(negedge clk);
      d = periph_data_out;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic measure(input logic [1:0] ch, output int period, output int high);
      logic prev, cur;
      bit   found;
      period = 0; high = 0; found = 0;
      prev = pwm_out[ch];
      for (int n = 0; n < 1200 && !found; n++) begin
         @(negedge clk); cur = pwm_out[ch];
         if (!prev && cur) found = 1;
         prev = cur;
      end
      if (found) begin
         found = 0; period = 1; high = 1;
         for (int k = 0; k < 1200 && !found; k++) begin
            @(negedge clk); cur = pwm_out[ch];
            if (!prev && cur) found = 1;
            else begin
               period++;
               if (cur) high++;
            end
            prev = cur;
         end
         if (!found) period = 0;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tests++; if (pwm_out !== 4'h0) begin fails++; $display("FAIL reset_pwm got %h want 0", pwm_out); end
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", irq); end
      tests++; if (periph_data_out !== 32'h0) begin fails++; $display("FAIL reset_dout got %h want 0", periph_data_out); end
      bus_read(A_MILLIS, LW, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_millis got %h want 0", d); end
      bus_read(A_TCTRL, LW, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_tctrl got %h want 0", d); end
   endtask

   task automatic test_counters();
      logic [31:0] d;
      do_reset();
      repeat (11998) @(negedge clk);
      bus_read(A_MILLIS, LW, d);
      tests++; if (d !== 32'd0) begin fails++; $display("FAIL millis_before got %0d want 0", d); end
      bus_read(A_MICROS, LW, d);
      tests++; if (d !== 32'd999) begin fails++; $display("FAIL micros_before got %0d want 999", d); end
      bus_read(A_MILLIS, LW, d);
      tests++; if (d !== 32'd1) begin fails++; $display("FAIL millis_1ms got %0d want 1", d); end
      bus_read(A_MICROS, LW, d);
      tests++; if (d !== 32'd1000) begin fails++; $display("FAIL micros_1ms got %0d want 1000", d); end
      force dut.millis_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.millis_q;
      bus_read(A_MILLIS, LW, d);
      tests++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL millis_preload got %h want ffffffff", d); end
      repeat (11996) @(negedge clk);
      bus_read(A_MILLIS, LW, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL millis_wrap got %h want 0", d); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] d;
      bus_write(32'hFFFF_FF81, LB, 32'h0000_0080);
      bus_read(A_PRESC, LW, d);
      tests++; if (d !== 32'h0000_8000) begin fails++; $display("FAIL sb_lw got %h want 00008000", d); end
      bus_read(32'hFFFF_FF81, LB, d);
      tests++; if (d !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb got %h want ffffff80", d); end
      bus_read(32'hFFFF_FF81, LBU, d);
      tests++; if (d !== 32'h0000_0080) begin fails++; $display("FAIL lbu got %h want 00000080", d); end
      bus_read(A_PRESC, LH, d);
      tests++; if (d !== 32'hFFFF_8000) begin fails++; $display("FAIL lh got %h want ffff8000", d); end
      bus_read(32'hFFFF_FF82, LHU, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL lhu_upper got %h want 0", d); end
      bus_write(32'hFFFF_FFF2, LH, 32'hDEAD_BEEF);
      bus_write(A_TCMP, LB, 32'h0000_0011);
      bus_write(32'h0000_00F0, LW, 32'h1234_5678);
      bus_read(A_TCMP, LW, d);
      tests++; if (d !== 32'hBEEF_0011) begin fails++; $display("FAIL sh_sb_merge got %h want beef0011", d); end
      bus_write(A_UNMAP, LW, 32'hFFFF_FFFF);
      bus_read(A_UNMAP, LW, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped got %h want 0", d); end
      bus_read(A_DUTY5, LW, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL duty_oob got %h want 0", d); end
      bus_read(32'h0000_1000, LW, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL off_page got %h want 0", d); end
      bus_write(A_PRESC, LW, 32'h0);
      bus_write(A_TCMP, LW, 32'h0);
   endtask

   task automatic test_pwm();
      logic [31:0] d;
      int per, hi, cnt;
      bus_write(A_DUTY2, LW, 32'h0000_0140);
      bus_read(A_DUTY2, LW, d);
      tests++; if (d !== 32'h40) begin fails++; $display("FAIL duty_rb got %h want 40", d); end
      repeat (300) @(negedge clk);
      measure(2'd2, per, hi);
      tests++; if (per != 256 || hi != 64) begin fails++; $display("FAIL pwm_64 got per=%0d hi=%0d want 256/64", per, hi); end
      bus_write(A_DUTY2, LB, 32'h0000_00FF);
      repeat (300) @(negedge clk);
      measure(2'd2, per, hi);
      tests++; if (per != 256 || hi != 255) begin fails++; $display("FAIL pwm_max got per=%0d hi=%0d want 256/255", per, hi); end
      bus_write(A_DUTY2, LW, 32'h0);
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (pwm_out != 4'h0) cnt++;
      end
      tests++; if (cnt != 0) begin fails++; $display("FAIL pwm_zero got %0d high cycles want 0", cnt); end
      bus_write(A_DUTY2, LW, 32'd64);
      bus_write(A_PRESC, LW, 32'd1);
      repeat (600) @(negedge clk);
      measure(2'd2, per, hi);
      tests++; if (per != 512 || hi != 128) begin fails++; $display("FAIL pwm_presc1 got per=%0d hi=%0d want 512/128", per, hi); end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      do_reset();
      bus_write(A_TCMP, LW, 32'd5);
      bus_write(A_TCTRL, LW, 32'h5);
      repeat (69) @(negedge clk);
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL os_pre got %b want 0", irq); end
      @(negedge clk);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL os_fire got %b want 1", irq); end
      bus_read(A_TCTRL, LW, d);
      tests++; if (d !== 32'hC) begin fails++; $display("FAIL os_tctrl got %h want c", d); end
      bus_read(A_TCOUNT, LW, d);
      tests++; if (d !== 32'd5) begin fails++; $display("FAIL os_tcount got %0d want 5", d); end
      bus_write(A_TCTRL, LW, 32'hC);
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL os_w1c got %b want 0", irq); end
      repeat (15) @(negedge clk);
      bus_read(A_TCOUNT, LW, d);
      tests++; if (d !== 32'd5) begin fails++; $display("FAIL os_hold got %0d want 5", d); end
      bus_read(A_TCTRL, LW, d);
      tests++; if (d !== 32'h4) begin fails++; $display("FAIL os_tctrl2 got %h want 4", d); end
      bus_write(A_TCTRL, LW, 32'h5);
      repeat (2) @(negedge clk);
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL os_rearm_pre got %b want 0", irq); end
      @(negedge clk);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL os_rearm got %b want 1", irq); end
   endtask

   task automatic test_periodic();
      logic [31:0] d;
      do_reset();
      bus_write(A_TCMP, LW, 32'd2);
      bus_write(A_TCTRL, LW, 32'h7);
      repeat (33) @(negedge clk);
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL per_pre got %b want 0", irq); end
      @(negedge clk);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL per_fire1 got %b want 1", irq); end
      repeat (4) @(negedge clk);
      bus_write(A_TCTRL, LW, 32'hF);
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL per_w1c got %b want 0", irq); end
      repeat (30) @(negedge clk);
      bus_write(A_TCTRL, LW, 32'hF);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL per_w1c_vs_set got %b want 1", irq); end
      bus_read(A_TCOUNT, LW, d);
      tests++; if (d !== 32'd0) begin fails++; $display("FAIL per_reload got %0d want 0", d); end
      bus_write(A_TCTRL, LW, 32'hF);
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL per_w1c2 got %b want 0", irq); end
      repeat (33) @(negedge clk);
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL per_pre3 got %b want 0", irq); end
      @(negedge clk);
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL per_fire3 got %b want 1", irq); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      bus_write(A_PRESC, LW, 32'd3);
      bus_write(A_DUTY0, LW, 32'd200);
      repeat (5) @(negedge clk);
      do_reset();
      tests++; if (pwm_out !== 4'h0 || irq !== 1'b0) begin fails++; $display("FAIL mid_reset_out got pwm=%h irq=%b want 0/0", pwm_out, irq); end
      bus_read(A_TCOUNT, LW, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL mid_reset_tcount got %h want 0", d); end
      bus_read(A_PRESC, LW, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL mid_reset_presc got %h want 0", d); end
      bus_read(A_TCTRL, LW, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL mid_reset_tctrl got %h want 0", d); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_counters();
      test_byte_lanes();
      test_pwm();
      test_oneshot();
      test_periodic();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
